pipeline_skid_buffer: RTL and testbench

Two-entry ready/valid skid buffer that decouples a producer from a consumer while sustaining one word per cycle. Every output (input_ready, output_valid, output_data) is driven straight from a flop, so no combinational path runs between the two sides and timing closes per stage. It sits directly upstream of pipeline registers and datapath stages and feeds them registered data. All of its storage is built from the existing `register` module.

---
 rtl/pipeline_skid_buffer_pkg.sv | 13 +
 rtl/register.sv | 21 ++
 rtl/pipeline_skid_buffer.sv | 134 +++++++++++++
 tb/tb_pipeline_skid_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipeline_skid_buffer_pkg.sv
// Shared state encodings and default sizing for the pipeline skid buffer.
package pipeline_skid_buffer_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT = 8;
  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/register.sv
// Generic clock-enabled register with synchronous active-high clear.
module register #(
  parameter int unsigned        WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             clock_enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= RESET_VALUE;
    end else if (clock_enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry ready/valid skid buffer; every output comes straight from a register.
module pipeline_skid_buffer
  import pipeline_skid_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] next_state_c;
  logic [WORD_WIDTH-1:0]  skid_reg;
  logic [WORD_WIDTH-1:0]  data_next_c;
  logic                   insert_c;
  logic                   remove_c;
  logic                   data_enable_c;
  logic                   data_from_skid_c;
  logic                   skid_enable_c;
  logic                   state_enable_c;
  logic                   ready_next_c;
  logic                   valid_next_c;
  logic                   ready_enable_c;
  logic                   valid_enable_c;

  assign insert_c = input_valid & input_ready;
  assign remove_c = output_valid & output_ready;

  // Next state and per-register load enables.
  always_comb begin
    next_state_c     = state;
    data_enable_c    = 1'b0;
    data_from_skid_c = 1'b0;
    skid_enable_c    = 1'b0;
    case (state)
      EMPTY: begin
        if (insert_c) begin
          next_state_c  = BUSY;
          data_enable_c = 1'b1;
        end
      end
      BUSY: begin
        if (insert_c && remove_c) begin
          data_enable_c = 1'b1;
        end else if (insert_c) begin
          next_state_c  = FULL;
          skid_enable_c = 1'b1;
        end else if (remove_c) begin
          next_state_c  = EMPTY;
        end
      end
      FULL: begin
        if (remove_c) begin
          next_state_c     = BUSY;
          data_enable_c    = 1'b1;
          data_from_skid_c = 1'b1;
        end
      end
      default: next_state_c = EMPTY;
    endcase
  end

  // Handshake flags are a registered decode of the next state.
  always_comb begin
    ready_next_c   = (next_state_c != STATE_WIDTH'(FULL));
    valid_next_c   = (next_state_c != STATE_WIDTH'(EMPTY));
    state_enable_c = (next_state_c != state);
    ready_enable_c = (ready_next_c != input_ready);
    valid_enable_c = (valid_next_c != output_valid);
    data_next_c    = data_from_skid_c ? skid_reg : input_data;
  end

  register #(
    .WIDTH       (STATE_WIDTH),
    .RESET_VALUE (STATE_WIDTH'(EMPTY))
  ) u_state (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (state_enable_c),
    .d            (next_state_c),
    .q            (state)
  );

  register #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_input_ready (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (ready_enable_c),
    .d            (ready_next_c),
    .q            (input_ready)
  );

  register #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_output_valid (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (valid_enable_c),
    .d            (valid_next_c),
    .q            (output_valid)
  );

  register #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE ('0)
  ) u_data_reg (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (data_enable_c),
    .d            (data_next_c),
    .q            (output_data)
  );

  register #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE ('0)
  ) u_skid_reg (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (skid_enable_c),
    .d            (input_data),
    .q            (skid_reg)
  );

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Self-checking bench for pipeline_skid_buffer against a FIFO-occupancy reference model.
module tb_pipeline_skid_buffer;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         input_valid = 1'b0;
  logic         input_ready;
  logic [W-1:0] input_data = '0;
  logic         output_valid;
  logic         output_ready = 1'b0;
  logic [W-1:0] output_data;

  int checks = 0;
  int errors = 0;

  // Reference model: words held, in arrival order, plus the last word shown.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_last = '0;

  pipeline_skid_buffer #(.WORD_WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare outputs after the edge.
  task automatic step(input logic clr, input logic iv, input logic [W-1:0] d,
                      input logic ordy, output logic accepted);
    logic ins;
    logic rem;
    clear        = clr;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    ins = iv && (model_q.size() < 2);
    rem = (model_q.size() > 0) && ordy;
    accepted = ins && !clr;
    if (!clr && output_valid === 1'b1 && ordy && model_q.size() > 0)
      check("order", 32'(output_data), 32'(model_q[0]));
    @(posedge clock);
    #1;
    if (clr) begin
      model_q.delete();
      model_last = '0;
    end else begin
      if (rem) void'(model_q.pop_front());
      if (ins) model_q.push_back(d);
      if (model_q.size() > 0) model_last = model_q[0];
    end
    check("input_ready", 32'(input_ready), 32'(model_q.size() < 2));
    check("output_valid", 32'(output_valid), 32'(model_q.size() > 0));
    check("output_data", 32'(output_data), 32'(model_last));
  endtask

  initial begin
    logic         acc;
    logic         pend;
    logic         iv;
    logic [W-1:0] word;

    // Reset
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    check("reset_ready", 32'(input_ready), 32'd1);
    check("reset_valid", 32'(output_valid), 32'd0);
    check("reset_data", 32'(output_data), 32'd0);

    // Flow-through at full rate
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, W'(i), 1'b1, acc);
      check("flow_accept", 32'(acc), 32'd1);
      check("flow_data", 32'(output_data), 32'(i));
      check("flow_ready", 32'(input_ready), 32'd1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("flow_empty", 32'(output_valid), 32'd0);

    // Fill under backpressure
    step(1'b0, 1'b1, 8'hA1, 1'b0, acc);
    check("fill_a1", 32'(acc), 32'd1);
    step(1'b0, 1'b1, 8'hA2, 1'b0, acc);
    check("fill_a2", 32'(acc), 32'd1);
    check("fill_ready", 32'(input_ready), 32'd0);
    step(1'b0, 1'b1, 8'hA3, 1'b0, acc);
    check("fill_a3_held", 32'(acc), 32'd0);
    check("fill_stable", 32'(output_data), 32'hA1);

    // Drain
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("drain_first", 32'(output_data), 32'hA2);
    check("drain_ready", 32'(input_ready), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("drain_valid", 32'(output_valid), 32'd0);

    // Mid-operation reset while full with both handshakes offered
    step(1'b0, 1'b1, 8'hB1, 1'b0, acc);
    step(1'b0, 1'b1, 8'hB2, 1'b0, acc);
    check("pre_clear_full", 32'(input_ready), 32'd0);
    step(1'b1, 1'b1, 8'hB3, 1'b1, acc);
    check("clear_valid", 32'(output_valid), 32'd0);
    check("clear_ready", 32'(input_ready), 32'd1);
    check("clear_data", 32'(output_data), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("clear_no_word", 32'(output_valid), 32'd0);

    // Simultaneous insert and remove in BUSY
    step(1'b0, 1'b1, 8'h55, 1'b0, acc);
    check("busy_55", 32'(output_data), 32'h55);
    step(1'b0, 1'b1, 8'h66, 1'b1, acc);
    check("swap_data", 32'(output_data), 32'h66);
    check("swap_ready", 32'(input_ready), 32'd1);
    check("swap_valid", 32'(output_valid), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("swap_drained", 32'(output_valid), 32'd0);

    // Random backpressure; producer holds an offered word until it is taken
    pend = 1'b0;
    word = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!pend) begin
        iv   = 1'($urandom % 2);
        word = W'($urandom);
      end else begin
        iv = 1'b1;
      end
      step(1'b0, iv, word, 1'($urandom % 2), acc);
      pend = iv && !acc;
    end

    // Final drain: everything accepted must come out
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check("final_empty", 32'(output_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
